// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius (Simon) game sequencer.
package genius_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GEN,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_INPUT,
        S_ROUND_OK,
        S_CHECK,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [1:0] C_GREEN  = 2'd0;
    localparam logic [1:0] C_RED    = 2'd1;
    localparam logic [1:0] C_YELLOW = 2'd2;
    localparam logic [1:0] C_BLUE   = 2'd3;

    localparam int SEQ_LEN = 16;

    function automatic logic [3:0] onehot2(input logic [1:0] c);
        logic [3:0] r;
        case (c)
            C_GREEN:  r = 4'b0001;
            C_RED:    r = 4'b0010;
            C_YELLOW: r = 4'b0100;
            C_BLUE:   r = 4'b1000;
            default:  r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/genius_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4); q exposes the two LSBs as the colour draw.
module genius_lfsr (
    input  logic       clk,
    input  logic       R,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [1:0] q
);

    logic [7:0] s;
    logic       fb;

    assign fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    assign q  = s[1:0];

    always_ff @(posedge clk) begin
        if (R) begin
            s <= 8'h00;
        end else if (load) begin
            // an all-zero seed would lock the register up
            s <= (seed == 8'h00) ? 8'h01 : seed;
        end else if (step) begin
            s <= {s[6:0], fb};
        end
    end

endmodule

// File: rtl/genius_game_ctrl.sv
// Genius game sequencer: builds a colour sequence, plays growing prefixes,
// checks the player's replies and drives the external round counter.
module genius_game_ctrl
    import genius_pkg::*;
#(
    parameter int         SHOW_T    = 12_500_000,
    parameter int         GAP_T     = 6_250_000,
    parameter int         TIMEOUT_T = 250_000_000,
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       R,
    input  logic       start,
    input  logic [3:0] btn,
    input  logic [3:0] level,
    input  logic       tc_i,
    output logic       cnt_E,
    output logic       cnt_R,
    output logic [3:0] led,
    output logic [3:0] round_o,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    localparam int TM1  = (SHOW_T > GAP_T) ? SHOW_T : GAP_T;
    localparam int TMAX = (TM1 > TIMEOUT_T) ? TM1 : TIMEOUT_T;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SHOW_END = TW'(SHOW_T - 1);
    localparam logic [TW-1:0] GAP_END  = TW'(GAP_T - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_T - 1);

    state_t        st, st_d;
    logic [TW-1:0] t, t_d, t_inc;
    logic [3:0]    j, j_d;
    logic [3:0]    rnd, rnd_d;
    logic [3:0]    lq, lq_d;
    logic [3:0]    g, g_d;
    logic [1:0]    seq [SEQ_LEN];
    logic [1:0]    lfsr_q;
    logic          ld, step;
    logic [3:0]    exp_btn;
    logic [3:0]    led_d;

    genius_lfsr u_lfsr (
        .clk  (clk),
        .R    (R),
        .load (ld),
        .seed (SEED),
        .step (step),
        .q    (lfsr_q)
    );

    assign t_inc   = (t == '1) ? t : t + TW'(1);
    assign exp_btn = onehot2(seq[j]);

    always_comb begin
        st_d  = st;
        t_d   = t;
        j_d   = j;
        rnd_d = rnd;
        lq_d  = lq;
        g_d   = g;
        ld    = 1'b0;
        step  = 1'b0;
        unique case (st)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    st_d = S_GEN;
                    g_d  = 4'd0;
                    lq_d = (level == 4'd0) ? 4'd1 : level;
                    ld   = 1'b1;
                end
            end
            S_GEN: begin
                step = 1'b1;
                g_d  = g + 4'd1;
                if (g == 4'd15) begin
                    st_d  = S_SHOW_ON;
                    rnd_d = 4'd1;
                    j_d   = 4'd0;
                    t_d   = '0;
                end
            end
            S_SHOW_ON: begin
                if (t == SHOW_END) begin
                    st_d = S_SHOW_OFF;
                    t_d  = '0;
                end else begin
                    t_d = t_inc;
                end
            end
            S_SHOW_OFF: begin
                if (t == GAP_END) begin
                    t_d = '0;
                    if (j == rnd - 4'd1) begin
                        st_d = S_INPUT;
                        j_d  = 4'd0;
                    end else begin
                        st_d = S_SHOW_ON;
                        j_d  = j + 4'd1;
                    end
                end else begin
                    t_d = t_inc;
                end
            end
            S_INPUT: begin
                if (btn == 4'd0) begin
                    if (t == TMO_END) st_d = S_LOSE;
                    else              t_d  = t_inc;
                end else if (btn == exp_btn) begin
                    // a correct press beats a coincident timeout
                    t_d = '0;
                    if (j == rnd - 4'd1) st_d = S_ROUND_OK;
                    else                 j_d  = j + 4'd1;
                end else begin
                    st_d = S_LOSE;
                end
            end
            S_ROUND_OK: st_d = S_CHECK;
            S_CHECK: begin
                if (tc_i || rnd == lq) begin
                    st_d = S_WIN;
                end else begin
                    st_d  = S_SHOW_ON;
                    rnd_d = (rnd == 4'd15) ? rnd : rnd + 4'd1;
                    j_d   = 4'd0;
                    t_d   = '0;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_comb begin
        led_d = 4'd0;
        case (st_d)
            S_SHOW_ON, S_LOSE: led_d = onehot2(seq[j_d]);
            S_WIN:             led_d = 4'hF;
            default:           led_d = 4'd0;
        endcase
    end

    // outputs are registered from the next state so they track st exactly
    always_ff @(posedge clk) begin
        if (R) begin
            st      <= S_IDLE;
            t       <= '0;
            j       <= 4'd0;
            rnd     <= 4'd0;
            lq      <= 4'd0;
            g       <= 4'd0;
            for (int i = 0; i < SEQ_LEN; i++) seq[i] <= 2'd0;
            led     <= 4'd0;
            cnt_E   <= 1'b0;
            cnt_R   <= 1'b1;
            round_o <= 4'd0;
            busy    <= 1'b0;
            win     <= 1'b0;
            lose    <= 1'b0;
        end else begin
            st  <= st_d;
            t   <= t_d;
            j   <= j_d;
            rnd <= rnd_d;
            lq  <= lq_d;
            g   <= g_d;
            if (st == S_GEN) seq[g] <= lfsr_q;
            led     <= led_d;
            cnt_E   <= (st_d == S_ROUND_OK);
            cnt_R   <= (st_d == S_IDLE) || (st_d == S_GEN) ||
                       (st_d == S_WIN)  || (st_d == S_LOSE);
            busy    <= !((st_d == S_IDLE) || (st_d == S_WIN) ||
                         (st_d == S_LOSE));
            round_o <= ((st_d == S_IDLE) || (st_d == S_GEN)) ? 4'd0 : rnd_d;
            win     <= (st_d == S_WIN);
            lose    <= (st_d == S_LOSE);
        end
    end

endmodule

// File: tb/tb_genius_game_ctrl.sv
// Randomized bench for genius_game_ctrl against a game-level reference
// model (colour list from the LFSR rule, round counter, win/lose rules).
module tb_genius_game_ctrl;

    localparam int         SHOW_T = 4;
    localparam int         GAP_T  = 2;
    localparam int         TMO    = 20;
    localparam logic [7:0] SEED   = 8'hA5;

    logic       clk = 1'b0;
    logic       R;
    logic       start;
    logic [3:0] btn;
    logic [3:0] level;
    logic       tc_i;
    logic       cnt_E;
    logic       cnt_R;
    logic [3:0] led;
    logic [3:0] round_o;
    logic       busy;
    logic       win;
    logic       lose;

    int total = 0;
    int bad   = 0;
    int mseq[16];
    int cnt   = 0;
    int tc_n  = 99;
    int ecount = 0;
    logic prev_e = 1'b0;

    genius_game_ctrl #(
        .SHOW_T    (SHOW_T),
        .GAP_T     (GAP_T),
        .TIMEOUT_T (TMO),
        .SEED      (SEED)
    ) dut (
        .clk     (clk),
        .R       (R),
        .start   (start),
        .btn     (btn),
        .level   (level),
        .tc_i    (tc_i),
        .cnt_E   (cnt_E),
        .cnt_R   (cnt_R),
        .led     (led),
        .round_o (round_o),
        .busy    (busy),
        .win     (win),
        .lose    (lose)
    );

    always #5 clk = ~clk;

    // external round counter: clears on cnt_R, counts cnt_E pulses
    always @(posedge clk) begin
        if (cnt_R === 1'b1)      cnt <= 0;
        else if (cnt_E === 1'b1) cnt <= cnt + 1;
    end
    assign tc_i = (cnt == tc_n);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cnt_E === 1'b1) begin
            ecount++;
            chk("cnt_e_pulse", {31'd0, prev_e}, 0);
        end
        prev_e = (cnt_E === 1'b1);
    end

    function automatic logic [3:0] oh(input int c);
        logic [3:0] v;
        v = 4'd1 << c;
        return v;
    endfunction

    task automatic build_seq();
        int s;
        int fb;
        s = (SEED == 8'h00) ? 1 : int'(SEED);
        for (int i = 0; i < 16; i++) begin
            mseq[i] = s % 4;
            fb = $countones(s & 8'hB8) % 2;
            s = ((s * 2) + fb) % 256;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] v);
        int g;
        g = ($urandom_range(0, 4) == 0) ? TMO - 1 : $urandom_range(0, 3);
        cyc(g);
        btn = v;
        @(negedge clk);
        btn = 4'd0;
    endtask

    // playback of round r; returns at the first INPUT cycle
    task automatic capture(input int r);
        int   dark;
        int   len;
        bit   found;
        bit   poked;
        logic [3:0] v;
        for (int k = 0; k < r; k++) begin
            dark  = 0;
            found = 0;
            for (int w = 0; w < 40 && !found; w++) begin
                if (led != 4'd0) found = 1;
                else begin
                    dark++;
                    @(negedge clk);
                end
            end
            chk("wait_led", {31'd0, found}, 1);
            if (!found) return;
            if (k > 0) chk("gap_len", dark, GAP_T);
            chk("led_colour", led, oh(mseq[k]));
            chk("round_show", round_o, r);
            chk("busy_show", busy, 1);
            v     = led;
            len   = 0;
            poked = 0;
            while (led == v && len < 50) begin
                len++;
                if (!poked && $urandom_range(0, 3) == 0) begin
                    poked = 1;
                    start = 1'b1;
                    btn   = 4'($urandom_range(1, 15));
                end
                @(negedge clk);
                start = 1'b0;
                btn   = 4'd0;
            end
            chk("show_len", len, SHOW_T);
        end
        chk("dark_after", led, 0);
        cyc(GAP_T);
    endtask

    // mode: 0 wrong colour, 1 timeout, 2 random multi-hot, 3 btn=0011
    task automatic run_game(input int lvl, input int fr, input int fp,
                            input int mode, input int tcn);
        int lq;
        int winr;
        int base;
        int g;
        bit found;
        logic [3:0] wv;
        lq   = (lvl == 0) ? 1 : lvl;
        tc_n = tcn;
        winr = (tcn < lq) ? tcn : lq;
        if (fr > winr) fr = 0;
        if (fr > 0) fp = fp % fr;
        level = 4'(lvl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        level = 4'($urandom);
        base  = ecount;
        chk("gen_busy", busy, 1);
        chk("gen_cnt_r", cnt_R, 1);
        chk("gen_win", win, 0);
        chk("gen_lose", lose, 0);
        chk("gen_round", round_o, 0);
        for (int r = 1; r <= winr; r++) begin
            capture(r);
            for (int p = 0; p < r; p++) begin
                if (r == fr && p == fp) begin
                    if (mode == 1) begin
                        for (int c = 1; c <= TMO; c++) begin
                            chk("lose_early", lose, 0);
                            @(negedge clk);
                        end
                    end else begin
                        g = $urandom_range(0, 3);
                        cyc(g);
                        if (mode == 0) begin
                            wv = oh((mseq[p] + $urandom_range(1, 3)) % 4);
                        end else if (mode == 2) begin
                            do wv = 4'($urandom_range(1, 15));
                            while ($countones(wv) < 2);
                        end else begin
                            wv = 4'b0011;
                        end
                        btn = wv;
                        @(negedge clk);
                        btn = 4'd0;
                    end
                    chk("lose_set", lose, 1);
                    chk("lose_led", led, oh(mseq[p]));
                    chk("lose_round", round_o, r);
                    chk("lose_busy", busy, 0);
                    chk("lose_win", win, 0);
                    chk("lose_cnt_r", cnt_R, 1);
                    cyc(5);
                    chk("lose_cnt_e", ecount - base, r - 1);
                    chk("lose_sticky", lose, 1);
                    return;
                end
                press(oh(mseq[p]));
            end
        end
        found = 0;
        for (int w = 0; w < 6 && !found; w++) begin
            if (win === 1'b1) found = 1;
            else @(negedge clk);
        end
        chk("wait_win", {31'd0, found}, 1);
        chk("win_led", led, 4'hF);
        chk("win_round", round_o, winr);
        chk("win_lose", lose, 0);
        chk("win_busy", busy, 0);
        chk("win_cnt_e", ecount - base, winr);
        cyc(3);
        chk("win_sticky", win, 1);
    endtask

    initial begin
        bit found;
        build_seq();
        R     = 1'b1;
        start = 1'b1;
        btn   = 4'd0;
        level = 4'd3;
        cyc(2);
        chk("rst_led", led, 0);
        chk("rst_cnt_r", cnt_R, 1);
        chk("rst_cnt_e", cnt_E, 0);
        chk("rst_busy", busy, 0);
        chk("rst_round", round_o, 0);
        chk("rst_win", win, 0);
        chk("rst_lose", lose, 0);
        R     = 1'b0;
        start = 1'b0;
        cyc(1);

        level = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int w = 0; w < 40 && !found; w++) begin
            if (led != 4'd0) found = 1;
            else @(negedge clk);
        end
        chk("mid_wait_led", {31'd0, found}, 1);
        R = 1'b1;
        @(negedge clk);
        R = 1'b0;
        chk("mid_led", led, 0);
        chk("mid_cnt_r", cnt_R, 1);
        chk("mid_busy", busy, 0);
        chk("mid_round", round_o, 0);
        cyc(2);
        chk("mid_idle", busy, 0);

        run_game(3, 0, 0, 0, 99);
        run_game(3, 2, 1, 0, 99);
        run_game(2, 2, 0, 1, 99);
        run_game(0, 0, 0, 0, 99);
        run_game(0, 0, 0, 0, 99);
        run_game(0, 1, 0, 3, 99);
        for (int n = 0; n < 18; n++) begin
            run_game($urandom_range(0, 15),
                     ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15),
                     $urandom_range(0, 14),
                     $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 99);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
